// File: rtl/ysyx_040066_div_pkg.sv
// Shared definitions for the iterative radix-2 divider.
//   XLEN          : datapath width (64 only)
//   OP_*          : ALUctr encodings (DIV/DIVU/REM/REMU)
//   div_state_e   : divider FSM states
//   ITER_D/ITER_W : iteration counts for 64-bit and W operations
//   sext_w        : sign-extend bit 31 into the upper word
package ysyx_040066_div_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  localparam logic [6:0] ITER_D = 7'd64;
  localparam logic [6:0] ITER_W = 7'd32;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

endpackage

// File: rtl/ysyx_040066_div_step.sv
// One combinational non-restoring division step.
//   part_rem_i  : partial remainder {A[63:0], Q[63:0]} without the A sign bit
//   prev_sign_i : sign of A from the previous step (0 -> subtract, 1 -> add)
//   divisor_i   : divisor magnitude
//   part_rem_o  : next {A[64:0], Q[63:0]} after shift and add/subtract
//   q_bit_o     : quotient bit shifted into Q[0] (1 when the new A is >= 0)
module ysyx_040066_div_step
  import ysyx_040066_div_pkg::*;
(
  input  logic [2*XLEN-1:0] part_rem_i,
  input  logic              prev_sign_i,
  input  logic [XLEN-1:0]   divisor_i,
  output logic [2*XLEN:0]   part_rem_o,
  output logic              q_bit_o
);

  logic [XLEN:0] upper_shifted;
  logic [XLEN:0] upper_next;

  // Left shift of {A,Q}: the new A is the old A[63:0] with the Q MSB appended.
  assign upper_shifted = part_rem_i[2*XLEN-1:XLEN-1];
  assign upper_next    = prev_sign_i ? (upper_shifted + {1'b0, divisor_i})
                                     : (upper_shifted - {1'b0, divisor_i});
  assign q_bit_o       = ~upper_next[XLEN];
  assign part_rem_o    = {upper_next, part_rem_i[XLEN-2:0], q_bit_o};

endmodule

// File: rtl/ysyx_040066_divider.sv
// Iterative radix-2 (non-restoring) divider for RV64M DIV/DIVU/REM/REMU(W).
//   clk, rst_n      : clock, asynchronous active-low reset
//   block           : pipeline stall, freezes all state
//   flush           : abort current operation, return to IDLE
//   in_valid/ready  : request handshake; src1 dividend, src2 divisor,
//                     ALUctr operation, is_w 32-bit variant
//   out_valid/ready : result handshake; result quotient or remainder
//   busy            : FSM not IDLE
//   state_o         : FSM state, for observation
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high and block is low; valid holds its payload until that edge.
module ysyx_040066_divider
  import ysyx_040066_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            block,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [1:0]      ALUctr,
  input  logic            is_w,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic [1:0]      state_o
);

  div_state_e        state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [2*XLEN:0]   prem_q, prem_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              sel_rem_q, sel_rem_d;
  logic              is_w_q, is_w_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand preparation at accept
  logic            op_signed;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_neg;
  logic            a_neg, b_neg, div_zero, overflow;
  logic [XLEN-1:0] spec_sel, spec_res;
  logic            accept;

  assign op_signed = (ALUctr == OP_DIV) || (ALUctr == OP_REM);
  assign a_ext = is_w ? (op_signed ? sext_w(src1) : {32'b0, src1[31:0]}) : src1;
  assign b_ext = is_w ? (op_signed ? sext_w(src2) : {32'b0, src2[31:0]}) : src2;
  assign a_neg = op_signed & a_ext[XLEN-1];
  assign b_neg = op_signed & b_ext[XLEN-1];
  // Negating the most-negative value wraps to itself, which is the correct
  // unsigned magnitude.
  assign a_abs = a_neg ? (~a_ext + 64'd1) : a_ext;
  assign b_abs = b_neg ? (~b_ext + 64'd1) : b_ext;
  assign min_neg  = is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
  assign div_zero = (b_ext == '0);
  assign overflow = op_signed && (a_ext == min_neg) && (b_ext == '1);
  // Divide-by-zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
  assign spec_sel = ALUctr[1] ? (div_zero ? a_ext : '0)
                              : (div_zero ? '1 : a_ext);
  assign spec_res = is_w ? sext_w(spec_sel) : spec_sel;

  assign in_ready  = (state_q == ST_IDLE) & ~block;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;
  assign state_o   = state_q;

  // Single iteration step
  logic [2*XLEN:0] step_rem;
  logic            step_q_bit;

  ysyx_040066_div_step u_step (
    .part_rem_i  (prem_q[2*XLEN-1:0]),
    .prev_sign_i (prem_q[2*XLEN]),
    .divisor_i   (divisor_q),
    .part_rem_o  (step_rem),
    .q_bit_o     (step_q_bit)
  );

  // Final correction
  logic [XLEN-1:0] rem_mag, quo_mag, rem_fix, quo_fix, fix_sel, fix_res;

  // The corrected remainder is below the divisor, so 64-bit wrap is exact.
  assign rem_mag = prem_q[2*XLEN] ? (prem_q[2*XLEN-1:XLEN] + divisor_q)
                                  : prem_q[2*XLEN-1:XLEN];
  // W operations shift the dividend in from Q[63:32]; quotient lands in Q[31:0].
  assign quo_mag = is_w_q ? {32'b0, prem_q[31:0]} : prem_q[XLEN-1:0];
  assign rem_fix = r_neg_q ? (~rem_mag + 64'd1) : rem_mag;
  assign quo_fix = q_neg_q ? (~quo_mag + 64'd1) : quo_mag;
  assign fix_sel = sel_rem_q ? rem_fix : quo_fix;
  assign fix_res = is_w_q ? sext_w(fix_sel) : fix_sel;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prem_d    = prem_q;
    divisor_d = divisor_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    sel_rem_d = sel_rem_q;
    is_w_d    = is_w_q;
    result_d  = result_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else if (!block) begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            divisor_d = b_abs;
            q_neg_d   = a_neg ^ b_neg;
            r_neg_d   = a_neg;
            sel_rem_d = ALUctr[1];
            is_w_d    = is_w;
            if (div_zero || overflow) begin
              result_d = spec_res;
              state_d  = ST_DONE;
            end else begin
              prem_d  = is_w ? {65'b0, a_abs[31:0], 32'b0} : {65'b0, a_abs};
              cnt_d   = is_w ? ITER_W : ITER_D;
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          prem_d = step_rem;
          cnt_d  = cnt_q - 7'd1;
          if (cnt_q == 7'd1) state_d = ST_FIX;
        end
        ST_FIX: begin
          result_d = fix_res;
          state_d  = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      prem_q    <= '0;
      divisor_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      sel_rem_q <= 1'b0;
      is_w_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prem_q    <= prem_d;
      divisor_q <= divisor_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      sel_rem_q <= sel_rem_d;
      is_w_q    <= is_w_d;
      result_q  <= result_d;
    end
  end

  // step_q_bit is already folded into step_rem[0].
  logic unused_ok;
  assign unused_ok = step_q_bit;

endmodule

// File: doc/ysyx_040066_divider.md
Name: ysyx_040066_divider

Overview:
- Iterative radix-2 integer divider; the inverse operation of the single-cycle-issue Booth/Wallace multiplier in the Multi execution unit.
- Implements the RV64M DIV/DIVU/REM/REMU instructions and their W variants.
- Sits beside the multiplier in the EX stage and shares its `block` stall input and its ALUctr/is_w decode style.
- Multi-cycle. It accepts one operation at a time and returns the result through a valid/ready pair.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- block  in  1  pipeline stall; while high, all state is frozen
- flush  in  1  abort the current operation; takes priority over everything except reset
- in_valid  in  1  operation request
- in_ready  out  1  divider idle and able to accept (= state IDLE & ~block)
- src1  in  64  dividend
- src2  in  64  divisor
- ALUctr  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- is_w  in  1  32-bit W variant
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- result  out  64  quotient or remainder
- busy  out  1  state is not IDLE

Behaviour:
- Reset values:
  - state=IDLE
  - out_valid=0, busy=0, result=0
  - internal registers are zero.
- Accept: fires on in_valid & in_ready at edge T.
  - Operands are latched at T.
  - For W: take the low 32 bits of each operand, sign-extended for 00/10 and zero-extended for 01/11.
  - For signed ops: take absolute values and record the quotient sign (src1 sign ^ src2 sign) and the remainder sign (src1 sign).
  - Iteration count N = 32 if is_w, else 64.
- Special cases are detected at accept and bypass iteration; state goes to DONE and out_valid rises at T+1.
  - Divisor zero: quotient = all ones; remainder = dividend (after W extension).
  - Signed overflow (dividend = most-negative, divisor = -1 at the operating width): quotient = dividend; remainder = 0.
- States:
  - IDLE: go to CALC on accept, or to DONE on accept with a special case.
  - CALC: one shift-subtract step per unblocked cycle over a (2·XLEN+1)-bit partial remainder. The counter decrements. Go to FIX when the counter reaches 0 after N steps.
  - FIX: one cycle. Apply the non-restoring remainder correction (add the divisor back if the remainder is negative), then the sign corrections. Select quotient (ALUctr[1]=0) or remainder (ALUctr[1]=1). For W, sign-extend bit 31 of the selection into 63:32; this applies to DIVUW/REMUW too. Then go to DONE.
  - DONE: out_valid=1 and result is held stable. Go to IDLE on out_valid & out_ready & ~block.
- Latency: normal ops present out_valid at T+N+2 (66 cycles for 64-bit, 34 for W) with no stalls.
- block=1: the state, counter, registers and out_valid are frozen; no accept or retire happens that cycle. Each blocked cycle extends latency by exactly one.
- flush=1: go to IDLE next edge from any state and drop out_valid; an in_valid in the same cycle is ignored.
- Asynchronous reset mid-operation: immediately returns to IDLE with outputs at reset values.
- No back-to-back accept in DONE. in_ready is first high in the cycle after retire.
- A result whose out_ready stays low is held indefinitely.

Decomposition:
- Shared package (ysyx_040066_div_pkg):
  - XLEN
  - ALUctr encodings DIV/DIVU/REM/REMU
  - state enum IDLE/CALC/FIX/DONE
  - iteration count constants 64/32
- Sub-module ysyx_040066_div_step: combinational single non-restoring step. It takes the partial remainder, divisor and previous sign, and returns the next partial remainder and quotient bit. It is instantiated once in CALC.

Test Plan:
- DIV src1=-7, src2=2 → quotient -3 (0xFFFF_FFFF_FFFF_FFFD), out_valid at T+66; REM with the same operands → 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVU src1=0xFFFF_FFFF_FFFF_FFFF, src2=0x10 → 0x0FFF_FFFF_FFFF_FFFF; REMU with the same operands → 0xF.
- Divide by zero: DIV 5/0 → 0xFFFF_FFFF_FFFF_FFFF and REM 5/0 → 5. Overflow: DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000, REM → 0. All of these present out_valid at T+1.
- W variants:
  - DIVW src1=0x1_8000_0000, src2=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000 (overflow path).
  - DIVUW 0xFFFF_FFFF / 1 → 0xFFFF_FFFF_FFFF_FFFF (sign-extended).
  - Normal W ops present out_valid at T+34.
- Control:
  - 3 cycles of block during CALC → out_valid at T+69.
  - flush at T+10 → IDLE, no out_valid, in_ready high at T+11.
  - out_ready held low for 5 cycles → result stable, then retire and in_ready high the next cycle.
  - rst_n low mid-CALC → outputs 0 and state IDLE asynchronously.
